// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per cycle, LSB first.
// Result and carry are registered and only change on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             fa_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  // Full adder on the current operand LSBs and the carry flop
  always_comb begin
    fa_bit   = ra[0] ^ rb[0] ^ c;
    c_next   = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    res_next = {fa_bit, res[WIDTH-1:1]};
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= res_next;
          c   <= c_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_next;
            carry <= c_next;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=2.
// Expected results come from plain integer addition.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       st8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cy8;

  logic       st2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cy2;

  int n_vec;
  int n_err;

  logic [7:0] psum [2];
  logic       pcar [2];

  serial_adder #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst  (rst),
    .start(st8),
    .a    (a8),
    .b    (b8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .carry(cy8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk  (clk),
    .rst  (rst),
    .start(st2),
    .a    (a2),
    .b    (b2),
    .busy (busy2),
    .done (done2),
    .sum  (sum2),
    .carry(cy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drive(input int w, input logic s,
                       input logic [7:0] av, input logic [7:0] bv);
    if (w == 8) begin
      st8 = s;
      a8  = av;
      b8  = bv;
    end else begin
      st2 = s;
      a2  = av[1:0];
      b2  = bv[1:0];
    end
  endtask

  task automatic obs(input int w, output logic bz, output logic dn,
                     output logic [7:0] sm, output logic cy);
    if (w == 8) begin
      bz = busy8;
      dn = done8;
      sm = sum8;
      cy = cy8;
    end else begin
      bz = busy2;
      dn = done2;
      sm = {6'b0, sum2};
      cy = cy2;
    end
  endtask

  // One full operation; inputs scrambled after the start edge.
  task automatic op(input int w, input logic [7:0] av,
                    input logic [7:0] bv, input bit hold);
    logic [7:0] msk;
    logic [8:0] full;
    logic [7:0] esum;
    logic       ecar;
    logic       bz;
    logic       dn;
    logic [7:0] sm;
    logic       cy;
    int         ix;
    ix   = (w == 8) ? 0 : 1;
    msk  = (w == 8) ? 8'hFF : 8'h03;
    full = {1'b0, av & msk} + {1'b0, bv & msk};
    esum = full[7:0] & msk;
    ecar = full[w];
    drive(w, 1'b1, av, bv);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < w; i++) begin
      obs(w, bz, dn, sm, cy);
      chk($sformatf("run%0d_busy", w), 32'(bz), 32'd1);
      chk($sformatf("run%0d_done", w), 32'(dn), 32'd0);
      chk($sformatf("run%0d_sumhold", w), 32'(sm), 32'(psum[ix]));
      chk($sformatf("run%0d_cyhold", w), 32'(cy), 32'(pcar[ix]));
      drive(w, 1'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
    end
    obs(w, bz, dn, sm, cy);
    chk($sformatf("done%0d_pulse", w), 32'(dn), 32'd1);
    chk($sformatf("done%0d_busy", w), 32'(bz), 32'd0);
    chk($sformatf("done%0d_sum %0h+%0h", w, av & msk, bv & msk),
        32'(sm), 32'(esum));
    chk($sformatf("done%0d_carry %0h+%0h", w, av & msk, bv & msk),
        32'(cy), 32'(ecar));
    drive(w, 1'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk);
    obs(w, bz, dn, sm, cy);
    chk($sformatf("idle%0d_done", w), 32'(dn), 32'd0);
    chk($sformatf("idle%0d_busy", w), 32'(bz), 32'd0);
    chk($sformatf("idle%0d_sum", w), 32'(sm), 32'(esum));
    chk($sformatf("idle%0d_carry", w), 32'(cy), 32'(ecar));
    drive(w, hold, av, bv);
    psum[ix] = esum;
    pcar[ix] = ecar;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    psum[0] = '0;
    psum[1] = '0;
    pcar[0] = 1'b0;
    pcar[1] = 1'b0;
    rst = 1'b1;
    drive(8, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_carry8", 32'(cy8), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_sum2", 32'(sum2), 32'd0);
    rst = 1'b0;

    op(8, 8'h0F, 8'h01, 1'b0);
    op(8, 8'hFF, 8'h01, 1'b0);
    op(8, 8'hFF, 8'hFF, 1'b0);
    op(8, 8'h00, 8'h00, 1'b0);
    op(8, 8'h12, 8'h34, 1'b0);

    op(8, 8'h80, 8'h80, 1'b1);
    op(8, 8'h80, 8'h80, 1'b1);
    op(8, 8'h80, 8'h80, 1'b0);

    drive(8, 1'b1, 8'h55, 8'hAA);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 8'h55, 8'hAA);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_carry", 32'(cy8), 32'd0);
    @(negedge clk);
    chk("abort_nodone", 32'(done8), 32'd0);
    rst = 1'b0;
    psum[0] = '0;
    psum[1] = '0;
    pcar[0] = 1'b0;
    pcar[1] = 1'b0;
    op(8, 8'h01, 8'h01, 1'b0);

    for (int i = 0; i < 40; i++)
      op(8, 8'($urandom), 8'($urandom), 1'($urandom));
    drive(8, 1'b0, 8'h00, 8'h00);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        op(2, 8'(x), 8'(y), 1'($urandom));
    drive(2, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
